// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the functional units / ROB and the CDB arbiter.
// The master side presents FU results and recovery info; the slave side arbitrates and broadcasts.
interface cdb_arbiter_if #(
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
);
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*ROB_W-1:0]  req_rob;
  logic [3*PREG_W-1:0] req_pd;
  logic [3*DATA_W-1:0] req_data;
  logic [ROB_W-1:0]    rob_head;
  logic                flush_valid;
  logic [ROB_W-1:0]    flush_tag;
  logic                cdb_valid;
  logic [ROB_W-1:0]    cdb_rob;
  logic [PREG_W-1:0]   cdb_pd;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_src;

  modport master (
    output req_valid, req_rob, req_pd, req_data, rob_head, flush_valid, flush_tag,
    input  req_ready, cdb_valid, cdb_rob, cdb_pd, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_rob, req_pd, req_data, rob_head, flush_valid, flush_tag,
    output req_ready, cdb_valid, cdb_rob, cdb_pd, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin grant onto a registered CDB,
// and age-based squashing of results younger than a mispredicted branch.
module cdb_arbiter #(
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Ages are measured from the ROB head so tag wrap-around compares correctly.
  function automatic logic younger(input logic [ROB_W-1:0] tag,
                                   input logic [ROB_W-1:0] ftag,
                                   input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] age_tag;
    logic [ROB_W-1:0] age_flush;
    age_tag   = tag - head;
    age_flush = ftag - head;
    return age_tag > age_flush;
  endfunction

  function automatic logic [1:0] wrap3(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  logic [2:0]        ready;
  logic [2:0]        eligible;
  logic [2:0]        grant;
  logic [ROB_W-1:0]  head_rob  [3];
  logic [PREG_W-1:0] head_pd   [3];
  logic [DATA_W-1:0] head_data [3];
  logic              win_any;
  logic [1:0]        win_idx;

  logic [1:0]        rr_reg;
  logic              cdb_valid_reg;
  logic [ROB_W-1:0]  cdb_rob_reg;
  logic [PREG_W-1:0] cdb_pd_reg;
  logic [DATA_W-1:0] cdb_data_reg;
  logic [1:0]        cdb_src_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fu
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic [DEPTH-1:0]  live_reg;
      logic [ROB_W-1:0]  rob_mem  [DEPTH];
      logic [PREG_W-1:0] pd_mem   [DEPTH];
      logic [DATA_W-1:0] data_mem [DEPTH];
      logic [ROB_W-1:0]  in_rob;
      logic [PREG_W-1:0] in_pd;
      logic [DATA_W-1:0] in_data;
      logic              push;
      logic              pop;
      logic              nonempty;
      logic              head_live;

      assign in_rob    = bus.req_rob[gi*ROB_W +: ROB_W];
      assign in_pd     = bus.req_pd[gi*PREG_W +: PREG_W];
      assign in_data   = bus.req_data[gi*DATA_W +: DATA_W];
      assign ready[gi] = (count_reg < CNT_W'(DEPTH));
      assign nonempty  = (count_reg != '0);
      assign head_live = live_reg[rd_ptr_reg];

      assign head_rob[gi]  = rob_mem[rd_ptr_reg];
      assign head_pd[gi]   = pd_mem[rd_ptr_reg];
      assign head_data[gi] = data_mem[rd_ptr_reg];

      // A head being squashed on this very edge must not reach the bus.
      assign eligible[gi] = nonempty && head_live &&
                            !(bus.flush_valid && younger(head_rob[gi], bus.flush_tag, bus.rob_head));
      assign push = bus.req_valid[gi] && ready[gi];
      assign pop  = grant[gi] || (nonempty && !head_live);

      always_ff @(posedge clk) begin
        if (push) begin
          rob_mem[wr_ptr_reg]  <= in_rob;
          pd_mem[wr_ptr_reg]   <= in_pd;
          data_mem[wr_ptr_reg] <= in_data;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          live_reg   <= '0;
        end else begin
          if (bus.flush_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
              if (younger(rob_mem[k], bus.flush_tag, bus.rob_head)) live_reg[k] <= 1'b0;
            end
          end
          if (push) begin
            live_reg[wr_ptr_reg] <= !(bus.flush_valid && younger(in_rob, bus.flush_tag, bus.rob_head));
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
          else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
        end
      end
    end
  endgenerate

  // Highest priority goes to the FU at the pointer; the last match in this loop wins.
  always_comb begin
    win_any = 1'b0;
    win_idx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (eligible[wrap3(rr_reg, k)]) begin
        win_any = 1'b1;
        win_idx = wrap3(rr_reg, k);
      end
    end
  end

  assign grant = win_any ? (3'b001 << win_idx) : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_reg        <= 2'd0;
      cdb_valid_reg <= 1'b0;
      cdb_rob_reg   <= '0;
      cdb_pd_reg    <= '0;
      cdb_data_reg  <= '0;
      cdb_src_reg   <= 2'd0;
    end else if (win_any) begin
      rr_reg        <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      cdb_valid_reg <= 1'b1;
      cdb_rob_reg   <= head_rob[win_idx];
      cdb_pd_reg    <= head_pd[win_idx];
      cdb_data_reg  <= head_data[win_idx];
      cdb_src_reg   <= win_idx;
    end else begin
      cdb_valid_reg <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_valid_reg;
  assign bus.cdb_rob   = cdb_rob_reg;
  assign bus.cdb_pd    = cdb_pd_reg;
  assign bus.cdb_data  = cdb_data_reg;
  assign bus.cdb_src   = cdb_src_reg;
endmodule
